long_alu_sequencer: RTL and testbench



---
 rtl/long_alu_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_long_alu_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/long_alu_sequencer.sv
// Multi-cycle sequencer driving one 16-bit ALU slice for word and long integer
// operations; long ops run low word then high word with the carry chained.
module long_alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic        size,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        use_x,
  input  logic        x_in,
  input  logic        z_in,
  output logic [31:0] result,
  output logic        done,
  output logic        c_out,
  output logic        v_out,
  output logic        z_out,
  output logic        n_out,
  output logic        x_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  // One 16-bit ALU pass; bit 16 is carry (ADD) or borrow (SUB), 0 otherwise.
  function automatic logic [16:0] alu_slice(input logic [2:0]  f,
                                            input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic        ci);
    logic [16:0] r;
    case (f)
      OP_ADD:  r = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      OP_SUB:  r = {1'b0, x} - {1'b0, y} - {16'd0, ci};
      OP_AND:  r = {1'b0, x & y};
      OP_OR:   r = {1'b0, x | y};
      OP_XOR:  r = {1'b0, x ^ y};
      default: r = {1'b0, x};
    endcase
    return r;
  endfunction

  state_t      state_r, next_s;
  logic [31:0] a_r, b_r;
  logic [2:0]  op_r;
  logic        size_r, use_x_r, x_in_r, z_in_r;
  logic [15:0] lo_res_r;
  logic        lo_c_r, lo_z_r;

  logic        ready_r, done_r;
  logic [31:0] result_r;
  logic        c_r, v_r, z_r, n_r, x_r;

  logic        addsub_s;
  logic [15:0] slice_a_s, slice_b_s;
  logic        slice_ci_s;
  logic [16:0] slice_s;
  logic [31:0] fin_res_s;
  logic        am_s, bm_s, rm_s, zero_s;
  logic        fin_c_s, fin_v_s, fin_z_s, fin_x_s;

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = LO;
        else       next_s = IDLE;
      end
      LO: begin
        if (size_r) next_s = HI;
        else        next_s = FIN;
      end
      HI:      next_s = FIN;
      FIN:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Slice operand selection and final result/flag merge for the msb pass.
  always_comb begin
    addsub_s = (op_r == OP_ADD) || (op_r == OP_SUB);
    if (state_r == HI) begin
      slice_a_s  = a_r[31:16];
      slice_b_s  = b_r[31:16];
      slice_ci_s = lo_c_r;
    end else begin
      slice_a_s  = a_r[15:0];
      slice_b_s  = b_r[15:0];
      slice_ci_s = use_x_r && addsub_s;
    end
    slice_s = alu_slice(op_r, slice_a_s, slice_b_s, slice_ci_s);

    // Word ops keep the upper destination word untouched.
    if (size_r) begin
      fin_res_s = {slice_s[15:0], lo_res_r};
      am_s      = a_r[31];
      bm_s      = b_r[31];
      zero_s    = lo_z_r && (slice_s[15:0] == 16'd0);
    end else begin
      fin_res_s = {a_r[31:16], slice_s[15:0]};
      am_s      = a_r[15];
      bm_s      = b_r[15];
      zero_s    = (slice_s[15:0] == 16'd0);
    end
    rm_s = slice_s[15];

    case (op_r)
      OP_ADD:  fin_v_s = (am_s == bm_s) && (rm_s != am_s);
      OP_SUB:  fin_v_s = (am_s != bm_s) && (rm_s != am_s);
      default: fin_v_s = 1'b0;
    endcase

    if (addsub_s) begin
      fin_c_s = slice_s[16];
      fin_x_s = slice_s[16];
    end else begin
      fin_c_s = 1'b0;
      fin_x_s = x_in_r;
    end

    if (use_x_r) fin_z_s = z_in_r && zero_s;
    else         fin_z_s = zero_s;
  end

  // State, operand latches, low-pass latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      op_r     <= 3'd0;
      size_r   <= 1'b0;
      use_x_r  <= 1'b0;
      x_in_r   <= 1'b0;
      z_in_r   <= 1'b0;
      lo_res_r <= 16'd0;
      lo_c_r   <= 1'b0;
      lo_z_r   <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      result_r <= 32'd0;
      c_r      <= 1'b0;
      v_r      <= 1'b0;
      z_r      <= 1'b0;
      n_r      <= 1'b0;
      x_r      <= 1'b0;
    end else begin
      state_r <= next_s;
      ready_r <= (next_s == IDLE);
      done_r  <= (next_s == FIN);
      if ((state_r == IDLE) && start) begin
        a_r     <= a;
        b_r     <= b;
        op_r    <= op;
        size_r  <= size;
        use_x_r <= use_x;
        x_in_r  <= x_in;
        z_in_r  <= z_in;
      end
      if (state_r == LO) begin
        lo_res_r <= slice_s[15:0];
        lo_c_r   <= slice_s[16];
        lo_z_r   <= (slice_s[15:0] == 16'd0);
      end
      if ((next_s == FIN) && (state_r != FIN)) begin
        result_r <= fin_res_s;
        c_r      <= fin_c_s;
        v_r      <= fin_v_s;
        z_r      <= fin_z_s;
        n_r      <= rm_s;
        x_r      <= fin_x_s;
      end
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign result = result_r;
  assign c_out  = c_r;
  assign v_out  = v_r;
  assign z_out  = z_r;
  assign n_out  = n_r;
  assign x_out  = x_r;

endmodule

// File: tb/tb_long_alu_sequencer.sv
// Directed-vector bench for long_alu_sequencer; expected values are hand-computed.
module tb_long_alu_sequencer;

  logic        clk, reset, start, ready, size, use_x, x_in, z_in, done;
  logic        c_out, v_out, z_out, n_out, x_out;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int base;

  long_alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .size(size),
    .op(op), .a(a), .b(b), .use_x(use_x), .x_in(x_in), .z_in(z_in),
    .result(result), .done(done), .c_out(c_out), .v_out(v_out),
    .z_out(z_out), .n_out(n_out), .x_out(x_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, x_out, n_out, z_out, v_out, c_out};
  endfunction

  // Flag vectors are packed {X,N,Z,V,C}.
  task automatic run_op(input string tag, input logic sz, input logic [2:0] o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic ux, input logic xi, input logic zi,
                        input logic [31:0] exp_res, input logic [4:0] exp_fl,
                        input int exp_lat);
    int cyc;
    @(negedge clk);
    size = sz; op = o; a = av; b = bv; use_x = ux; x_in = xi; z_in = zi;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
    end while (!done && cyc < 10);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, flags(), {27'd0, exp_fl});
    check({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; size = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    use_x = 1'b0; x_in = 1'b0; z_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", flags(), 32'd0);
    reset = 1'b0;

    //      tag        sz    op    a             b             ux    xi    zi    result        XNZVC     lat
    run_op("ladd",   1'b1, 3'd0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 5'b00000, 3);
    run_op("wadd",   1'b0, 3'd0, 32'h1234FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h12340000, 5'b10101, 2);
    run_op("lsub",   1'b1, 3'd1, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 5'b11001, 3);
    run_op("lovf",   1'b1, 3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 5'b01010, 3);
    run_op("addx_z0",1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 5'b10001, 3);
    run_op("addx_z1",1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'h00000000, 5'b10101, 3);
    run_op("wsub",   1'b0, 3'd1, 32'hABCD0005, 32'h00000007, 1'b0, 1'b0, 1'b0, 32'hABCDFFFE, 5'b11001, 2);
    run_op("wand",   1'b0, 3'd2, 32'h0000F0F0, 32'h12340FF0, 1'b0, 1'b1, 1'b0, 32'h000000F0, 5'b10000, 2);
    run_op("wovf",   1'b0, 3'd0, 32'h00007FFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00008000, 5'b01010, 2);
    run_op("lpass",  1'b1, 3'd6, 32'h80000000, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h80000000, 5'b01000, 3);
    run_op("lor",    1'b1, 3'd3, 32'h00F00000, 32'h0000000F, 1'b0, 1'b0, 1'b0, 32'h00F0000F, 5'b00000, 3);

    // Long XOR with start held high through LO and HI: only one done.
    base = done_cnt;
    @(negedge clk);
    size = 1'b1; op = 3'd4; a = 32'hFFFF0000; b = 32'hFFFF0000;
    use_x = 1'b0; x_in = 1'b1; z_in = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("xor_done", {31'd0, done}, 32'd1);
    check("xor_result", result, 32'd0);
    check("xor_flags", flags(), 32'h00000014);
    repeat (6) @(negedge clk);
    check("xor_one_done", done_cnt - base, 32'd1);

    // Reset during HI aborts with no done.
    @(negedge clk);
    size = 1'b1; op = 3'd0; a = 32'h11112222; b = 32'h33334444; x_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    base = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_flags", flags(), 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - base, 32'd0);
    run_op("post_abort", 1'b0, 3'd0, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0, 32'h00000003, 5'b00000, 2);

    // start and reset together: request dropped.
    base = done_cnt;
    @(negedge clk);
    size = 1'b0; op = 3'd0; a = 32'h5; b = 32'h6; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (5) @(negedge clk);
    check("start_rst_no_done", done_cnt - base, 32'd0);
    check("start_rst_ready", {31'd0, ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures = failures + 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
